sub_shift_stage: RTL and testbench
==================================

# sub_shift_stage

Column-serial AES SubBytes + ShiftRows stage with valid/ready handshakes on both sides. It sits directly upstream of the combinational MixColumns stage in the round datapath and delivers a fully substituted and row-shifted 128-bit state. It uses 4 shared S-box lookups over 4 cycles instead of 16 in parallel, trading latency for area.

## Interface
- No parameters; state width is fixed at 128 bits.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream presents a state.
- in_ready  out  1  stage can accept a state this cycle.
- in_state  in  [0:127]  input state.
- out_valid  out  1  out_state holds a finished result.
- out_ready  in  1  downstream (MixColumns) consumes the result this cycle.
- out_state  out  [0:127]  SubBytes+ShiftRows result, registered.
- busy  out  1  high while in BUSY.
- inv  in  1  present only with AES_SUB_INV_EN; selects inverse operation.
- State layout for in_state and out_state: byte k = bits [8k:8k+7], bit 0 is the MSB, row r = k%4, column c = k/4.

## Operation
- FSM states: IDLE, BUSY, DONE. Column counter cnt is 2 bits.
- in_ready = (IDLE) or (DONE and out_ready).
- Accept on in_valid && in_ready:
  - register in_state into src;
  - cnt <= 0;
  - go to BUSY;
  - with the macro, also latch inv into mode.
- BUSY, each cycle:
  - S-box the 4 bytes of src column cnt;
  - write source byte (r,c) into result position (r, (c−r) mod 4), i.e. result index 4·((c−r)&3)+r;
  - cnt increments;
  - at cnt==3, go to DONE instead.
- DONE:
  - out_valid=1; out_state holds stable until out_ready.
  - out_ready without in_valid: go to IDLE.
  - out_ready with in_valid: accept the new state in the same cycle and go to BUSY.
- in_state changes after acceptance have no effect.
- out_ready is ignored outside DONE.
- Reset (any time, including mid-operation) discards work.
- Reset values: state IDLE, cnt 0, src 0, out_state 0, out_valid 0, busy 0, in_ready 1.

## Timing
- Latency: an accept at edge T0 gives out_valid=1 after edge T4.
- Back-to-back throughput: one state per 5 cycles.
- out_state is registered; there is no combinational path from in_state to out_state.
- in_ready depends combinationally on out_ready in DONE only.
- in_valid and out_ready must not be combinationally derived from in_ready or out_valid respectively.

## Configuration
- AES_SUB_INV_EN defined:
  - adds the inv port.
  - When mode=1: inverse S-box, and destination (r, (c+r) mod 4) (InvShiftRows). Both operations are byte-wise, so the combined order is irrelevant.
  - When mode=0: identical to the build without the macro.
- AES_SUB_INV_EN undefined: no inv port; forward operation only; no inverse tables synthesised.

## Structure
- Shared package aes_pkg holds:
  - AES_STATE_W=128;
  - the FSM state encoding;
  - forward and inverse S-box constant tables;
  - helper function for the shifted destination index (r, c, inverse flag).
- Sub-module aes_sbox: combinational 8-bit lookup with an inv select (inverse path present only under AES_SUB_INV_EN). Instantiate it 4 times.

## Test plan
- FIPS-197 App. B round 1:
  - stimulus: in_state=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1.
  - required response: out_state=d4bf5d30e0b452aeb84111f11e2798e5, with out_valid rising exactly after the 4th edge post-accept.
- All-zero input:
  - stimulus: in_state=0.
  - required response: out_state=6363…63 (16 bytes of 0x63).
- Back-pressure:
  - stimulus: hold out_ready=0 for 3 cycles in DONE, and toggle in_valid/in_state meanwhile.
  - required response: out_state and out_valid stable; in_ready=0; the result is consumed on the first out_ready=1 cycle.
- Back-to-back:
  - stimulus: in_valid held high with out_ready=1 over 3 distinct states.
  - required response: the result of each state is correct; accepts 5 cycles apart; in_ready high in the DONE cycle.
- Reset mid-operation:
  - stimulus: deassert rst_n during BUSY at cnt=2.
  - required response: outputs immediately at reset values; the next accepted state produces a correct result.
- With AES_SUB_INV_EN:
  - stimulus: inv=1, in_state=d4bf5d30e0b452aeb84111f11e2798e5.
  - required response: out_state=193de3bea0f4e22b9ac68d2ae9f84808; inv=1 with in_state=6363…63 gives all-zero.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the column-serial SubBytes/ShiftRows stage:
//   - AES_STATE_W       : width of an AES state (128 bits)
//   - stage_state_t     : FSM encoding for sub_shift_stage
//   - sbox_fwd()        : forward S-box lookup
//   - sbox_inv()        : inverse S-box lookup (only with AES_SUB_INV_EN)
//   - shift_dest()      : destination byte index for (Inv)ShiftRows
// Optional feature macro: AES_SUB_INV_EN (adds the inverse S-box table).
// -----------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_STATE_W = 128;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } stage_state_t;

   // Table entry x occupies bits [8x : 8x+7]; ascending range keeps entry 0 leftmost.
   localparam logic [0:2047] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
      return SBOX_FWD[{x, 3'b000} +: 8];
   endfunction

`ifdef AES_SUB_INV_EN
   localparam logic [0:2047] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] sbox_inv(input logic [7:0] x);
      return SBOX_INV[{x, 3'b000} +: 8];
   endfunction
`endif

   // Byte index of row r in column c is 4*c + r, i.e. {c, r}.
   // Forward ShiftRows moves (r,c) to column (c-r) mod 4, the inverse to (c+r) mod 4;
   // 2-bit arithmetic provides the mod 4 for free.
   function automatic logic [3:0] shift_dest(input logic [1:0] r,
                                             input logic [1:0] c,
                                             input logic       inv);
      logic [1:0] col;
      col = inv ? (c + r) : (c - r);
      return {col, r};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational 8-bit AES S-box lookup.
// Ports:
//   data    in  [7:0]  byte to substitute
//   inv     in  1      select inverse S-box (only with AES_SUB_INV_EN)
//   result  out [7:0]  substituted byte
// Optional feature macro: AES_SUB_INV_EN (adds the inv port and inverse path).
// -----------------------------------------------------------------------------
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] data,
`ifdef AES_SUB_INV_EN
   input  logic       inv,
`endif
   output logic [7:0] result
);

`ifdef AES_SUB_INV_EN
   assign result = inv ? sbox_inv(data) : sbox_fwd(data);
`else
   assign result = sbox_fwd(data);
`endif

endmodule

// File: rtl/sub_shift_stage.sv
// -----------------------------------------------------------------------------
// sub_shift_stage
// Column-serial AES SubBytes + ShiftRows. One column (4 bytes) is substituted
// per cycle through 4 shared S-boxes and scattered straight into its shifted
// position in the registered output, so a state takes 4 BUSY cycles.
// Ports:
//   clk        in  1        clock, rising edge
//   rst_n      in  1        asynchronous active-low reset
//   in_valid   in  1        upstream presents in_state
//   in_ready   out 1        stage accepts a state this cycle
//   in_state   in  [0:127]  input state, byte k = bits [8k:8k+7]
//   out_valid  out 1        out_state holds a finished result
//   out_ready  in  1        downstream consumes the result this cycle
//   out_state  out [0:127]  SubBytes+ShiftRows result (registered)
//   busy       out 1        high while substituting
//   inv        in  1        inverse operation select (only with AES_SUB_INV_EN)
// Optional feature macro: AES_SUB_INV_EN (adds inv: InvSubBytes + InvShiftRows).
// -----------------------------------------------------------------------------
module sub_shift_stage
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] in_state,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] out_state,
   output logic         busy
`ifdef AES_SUB_INV_EN
   ,
   input  logic         inv
`endif
);

   stage_state_t state;
   logic [1:0]   cnt;
   logic [0:127] src;
   logic         mode_eff;
   logic         accept;
   logic [7:0]   col_byte [4];
   logic [7:0]   sub_byte [4];
   logic [0:127] next_out;

`ifdef AES_SUB_INV_EN
   logic mode;
   assign mode_eff = mode;
`else
   assign mode_eff = 1'b0;
`endif

   // A finished result may be replaced in the same cycle it is consumed.
   assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   // Four lanes: lane g handles row g of the column selected by cnt.
   for (genvar g = 0; g < 4; g++) begin : g_lane
      localparam logic [1:0] ROW = 2'(g);

      assign col_byte[g] = src[{cnt, ROW, 3'b000} +: 8];

      aes_sbox u_sbox (
         .data   (col_byte[g]),
`ifdef AES_SUB_INV_EN
         .inv    (mode),
`endif
         .result (sub_byte[g])
      );
   end

   // Scatter the 4 substituted bytes into their shifted positions; every other
   // byte keeps its current value.
   always_comb begin
      // NOTE: start from a full default so no path leaves next_out unassigned (no latch).
      next_out = out_state;
      for (int r = 0; r < 4; r++) begin
         next_out[{shift_dest(2'(r), cnt, mode_eff), 3'b000} +: 8] = sub_byte[r];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: src and out_state are plain registers (not RAM), so they reset
         // to 0 with the rest of the state.
         state     <= ST_IDLE;
         cnt       <= 2'd0;
         src       <= '0;
         out_state <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef AES_SUB_INV_EN
         mode      <= 1'b0;
`endif
      end else if (accept) begin
         // Covers both IDLE and the consume-and-reload case in DONE.
         state     <= ST_BUSY;
         cnt       <= 2'd0;
         src       <= in_state;
         out_valid <= 1'b0;
         busy      <= 1'b1;
`ifdef AES_SUB_INV_EN
         mode      <= inv;
`endif
      end else begin
         case (state)
            ST_BUSY: begin
               out_state <= next_out;
               cnt       <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sub_shift_stage.sv
// -----------------------------------------------------------------------------
// tb_sub_shift_stage
// Directed self-checking bench for sub_shift_stage using FIPS-197 vectors.
// Inverse vectors are exercised when built with AES_SUB_INV_EN.
// -----------------------------------------------------------------------------
module tb_sub_shift_stage;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [0:127] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [0:127] out_state;
   logic         busy;
`ifdef AES_SUB_INV_EN
   logic         inv;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [0:127] FIPS_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [0:127] FIPS_OUT  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [0:127] R2_IN     = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [0:127] R2_OUT    = 128'h49db873b453953897f02d2f177de961a;
   localparam logic [0:127] ZERO_IN   = 128'h0;
   localparam logic [0:127] ZERO_OUT  = 128'h63636363636363636363636363636363;
   localparam logic [0:127] JUNK      = 128'hdeadbeefcafef00d0123456789abcdef;

   sub_shift_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
`ifdef AES_SUB_INV_EN
      ,
      .inv       (inv)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] actual,
                        input logic [127:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Accept st at the next edge, then follow the 4 BUSY cycles and check the
   // result in DONE. Caller sets out_ready beforehand.
   task automatic run_to_done(input string tag, input logic [0:127] st,
                              input logic [0:127] expected);
      in_valid = 1'b1;
      in_state = st;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_state = JUNK;
      check({tag, " busy after accept"}, 128'(busy), 128'(1'b1));
      for (int i = 0; i < 3; i++) begin
         check({tag, " out_valid low in busy"}, 128'(out_valid), 128'(1'b0));
         @(posedge clk); #1;
      end
      check({tag, " out_valid low before 4th edge"}, 128'(out_valid), 128'(1'b0));
      @(posedge clk); #1;
      check({tag, " out_valid after 4th edge"}, 128'(out_valid), 128'(1'b1));
      check({tag, " out_state"}, out_state, expected);
   endtask

   // Full transaction with immediate consumption, returning to IDLE.
   task automatic run_one(input string tag, input logic [0:127] st,
                          input logic [0:127] expected);
      out_ready = 1'b1;
      run_to_done(tag, st, expected);
      @(posedge clk); #1;
      check({tag, " out_valid after consume"}, 128'(out_valid), 128'(1'b0));
      check({tag, " in_ready in idle"}, 128'(in_ready), 128'(1'b1));
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_state  = '0;
      out_ready = 1'b0;
`ifdef AES_SUB_INV_EN
      inv       = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset out_valid", 128'(out_valid), 128'(1'b0));
      check("reset busy", 128'(busy), 128'(1'b0));
      check("reset in_ready", 128'(in_ready), 128'(1'b1));
      check("reset out_state", out_state, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FIPS-197 App. B round 1 and all-zero input.
      run_one("fips_r1", FIPS_IN, FIPS_OUT);
      run_one("zero", ZERO_IN, ZERO_OUT);

      // Back-pressure: hold the result in DONE for 3 cycles while in_valid/in_state toggle.
      out_ready = 1'b0;
      run_to_done("bp", R2_IN, R2_OUT);
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid;
         in_state = JUNK ^ 128'(i);
         #1;
         check("bp in_ready low", 128'(in_ready), 128'(1'b0));
         @(posedge clk); #1;
         check("bp out_valid held", 128'(out_valid), 128'(1'b1));
         check("bp out_state held", out_state, R2_OUT);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp consumed", 128'(out_valid), 128'(1'b0));
      check("bp back to idle", 128'(busy), 128'(1'b0));

      // Back-to-back: in_valid high across 3 states; accepts land 5 cycles apart.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = FIPS_IN;
      @(posedge clk); #1;
      in_state = R2_IN;
      for (int s = 0; s < 3; s++) begin
         logic [0:127] exp_s;
         exp_s = (s == 0) ? FIPS_OUT : (s == 1) ? R2_OUT : ZERO_OUT;
         check("b2b busy", 128'(busy), 128'(1'b1));
         repeat (3) @(posedge clk);
         #1;
         check("b2b out_valid low before done", 128'(out_valid), 128'(1'b0));
         @(posedge clk); #1;
         check("b2b out_valid", 128'(out_valid), 128'(1'b1));
         check("b2b out_state", out_state, exp_s);
         check("b2b in_ready in done", 128'(in_ready), 128'(s < 2 ? 1'b1 : 1'b1));
         if (s == 1) in_state = ZERO_IN;
         if (s == 2) in_valid = 1'b0;
         @(posedge clk); #1;
         if (s == 0) in_state = ZERO_IN;
      end
      check("b2b final idle", 128'(out_valid), 128'(1'b0));
      check("b2b final not busy", 128'(busy), 128'(1'b0));

      // Reset in BUSY with cnt=2: outputs clear immediately, then a clean run.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = FIPS_IN;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid reset out_valid", 128'(out_valid), 128'(1'b0));
      check("mid reset busy", 128'(busy), 128'(1'b0));
      check("mid reset in_ready", 128'(in_ready), 128'(1'b1));
      check("mid reset out_state", out_state, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_one("after_reset", FIPS_IN, FIPS_OUT);

`ifdef AES_SUB_INV_EN
      inv = 1'b1;
      run_one("inv_fips", FIPS_OUT, FIPS_IN);
      run_one("inv_63", ZERO_OUT, ZERO_IN);
      inv = 1'b0;
      run_one("fwd_after_inv", R2_IN, R2_OUT);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
